// File: rtl/booth4_seq_mult_if.sv
// Operand/result bundle between the operand generator (master) and the Booth multiplier (slave).
// The generator drives operator and watches finish; the multiplier returns product, finish and busy.
interface booth4_seq_mult_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] operator;
  logic [2*WIDTH-1:0] product;
  logic               finish;
  logic               busy;

  modport master (output operator, input product, input finish, input busy);
  modport slave  (input operator, output product, output finish, output busy);
endinterface

// File: rtl/booth4_seq_mult.sv
// Sequential radix-4 Booth multiplier, WIDTH/2 iterations (WIDTH/2+1 unsigned); restarts when operator differs from the captured word.
// Macro BOOTH4_SIGNED_EN selects two's-complement operands; undefined gives unsigned operands zero-extended by 2 bits.
module booth4_seq_mult #(
  parameter int WIDTH     = 16,
  parameter int DONE_HOLD = 2
) (
  input logic              clk,
  input logic              rst_n,
  booth4_seq_mult_if.slave bus
);

`ifdef BOOTH4_SIGNED_EN
  localparam int BW = WIDTH;
`else
  localparam int BW = WIDTH + 2;
`endif
  localparam int N  = BW / 2;
  localparam int PW = WIDTH + 2;
  // Two guard bits above the partial product keep the running sum from wrapping before the shift.
  localparam int AW = WIDTH + 4;
  localparam int LO = 2 * WIDTH - BW;
  localparam int CW = $clog2(N + 1);
  localparam int HW = $clog2(DONE_HOLD + 2);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] r_op_q;
  logic [AW-1:0]      r_acc;
  logic [BW-1:0]      r_b;
  logic               r_bm1;
  logic [CW-1:0]      r_cnt;
  logic [HW-1:0]      r_hold;
  logic [2*WIDTH-1:0] r_product;
  logic               r_finish;
  logic               r_busy;

  logic               w_finish_nxt;
  logic               w_busy_nxt;
  logic               w_hold_ok;
  logic               w_start;
  logic               w_last;
  logic [PW-1:0]      w_a_ext;
  logic [BW-1:0]      w_b_init;
  logic [2:0]         w_trip;
  logic [PW-1:0]      w_pp;
  logic [AW-1:0]      w_sum;
  logic [AW-1:0]      w_acc_nxt;
  logic [BW-1:0]      w_b_nxt;

`ifdef BOOTH4_SIGNED_EN
  assign w_a_ext  = {{2{r_op_q[2*WIDTH-1]}}, r_op_q[2*WIDTH-1:WIDTH]};
  assign w_b_init = bus.operator[WIDTH-1:0];
`else
  assign w_a_ext  = {2'b00, r_op_q[2*WIDTH-1:WIDTH]};
  assign w_b_init = {2'b00, bus.operator[WIDTH-1:0]};
`endif

  assign w_hold_ok = (r_hold >= HW'(DONE_HOLD));
  assign w_start   = (r_state == S_IDLE) ||
                     ((r_state == S_DONE) && w_hold_ok && (bus.operator != r_op_q));
  assign w_last    = (r_state == S_CALC) && (r_cnt == CW'(N - 1));

  assign w_trip    = {r_b[1], r_b[0], r_bm1};

  always_comb begin
    w_pp = '0;
    case (w_trip)
      3'b001, 3'b010: w_pp = w_a_ext;
      3'b011:         w_pp = w_a_ext << 1;
      3'b100:         w_pp = -(w_a_ext << 1);
      3'b101, 3'b110: w_pp = -w_a_ext;
      default:        w_pp = '0;
    endcase
  end

  assign w_sum     = r_acc + {{(AW-PW){w_pp[PW-1]}}, w_pp};
  assign w_acc_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_b_nxt   = {w_sum[1:0], r_b[BW-1:2]};

  // State register; finish/busy are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_finish <= w_finish_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_CALC;
      S_CALC:  if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (w_start) w_state_nxt = S_CALC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_finish_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt   = (w_state_nxt == S_CALC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_q    <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_bm1     <= 1'b0;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_product <= '0;
    end else begin
      if (w_start) begin
        r_op_q <= bus.operator;
        r_acc  <= '0;
        r_b    <= w_b_init;
        r_bm1  <= 1'b0;
        r_cnt  <= '0;
      end else if (r_state == S_CALC) begin
        r_acc  <= w_acc_nxt;
        r_b    <= w_b_nxt;
        r_bm1  <= r_b[1];
        r_cnt  <= r_cnt + CW'(1);
      end

      if (w_last) begin
        r_product <= {w_acc_nxt[LO-1:0], w_b_nxt};
      end

      // The first cycle in DONE already counts toward the hold.
      if (w_last) begin
        r_hold <= HW'(1);
      end else if (w_start) begin
        r_hold <= '0;
      end else if ((r_state == S_DONE) && !w_hold_ok) begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign bus.product = r_product;
  assign bus.finish  = r_finish;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Directed-vector bench for booth4_seq_mult (WIDTH=16, DONE_HOLD=2), plus mid-CALC change, mid-CALC reset and a closed-loop run.
// Expected values follow BOOTH4_SIGNED_EN, matching the build of the design.
module tb_booth4_seq_mult;

  localparam int W  = 16;
  localparam int DH = 2;
`ifdef BOOTH4_SIGNED_EN
  localparam bit SGN = 1'b1;
  localparam int N   = W / 2;
`else
  localparam bit SGN = 1'b0;
  localparam int N   = W / 2 + 1;
`endif

  typedef struct {
    logic [2*W-1:0] op;
    logic [2*W-1:0] exp_s;
    logic [2*W-1:0] exp_u;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  booth4_seq_mult_if #(.WIDTH(W)) bif ();

  booth4_seq_mult #(.WIDTH(W), .DONE_HOLD(DH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [2*W-1:0] op);
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
`ifdef BOOTH4_SIGNED_EN
    a = {{W{op[2*W-1]}}, op[2*W-1:W]};
    b = {{W{op[W-1]}}, op[W-1:0]};
`else
    a = {{W{1'b0}}, op[2*W-1:W]};
    b = {{W{1'b0}}, op[W-1:0]};
`endif
    return a * b;
  endfunction

  // Present a new operand at a negedge while DONE hold has expired; check restart, latency, product.
  task automatic run_op(input logic [2*W-1:0] op, input logic [2*W-1:0] exp, input string nm);
    int lat;
    bif.operator = op;
    @(negedge clk);
    lat = 1;
    check({nm, "_busy"}, 64'(bif.busy), 64'd1);
    check({nm, "_fin_lo"}, 64'(bif.finish), 64'd0);
    while (!bif.finish && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"}, 64'(lat), 64'(N + 1));
    check({nm, "_prod"}, 64'(bif.product), 64'(exp));
    repeat (DH) @(negedge clk);
  endtask

  vec_t           vecs [12];
  logic [2*W-1:0] cur;
  logic [2*W-1:0] last_res;
  int             lat;
  int             len;
  int             drops;
  int             min_len;
  int             unstable;
  int             n_to;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{32'h0003_0004, 32'h0000_000C, 32'h0000_000C};
    vecs[1]  = '{32'h7FFF_8000, 32'hC000_8000, 32'h3FFF_8000};
    vecs[2]  = '{32'hFFFF_0002, 32'hFFFF_FFFE, 32'h0001_FFFE};
    vecs[3]  = '{32'h8000_8000, 32'h4000_0000, 32'h4000_0000};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFE_0001};
    vecs[5]  = '{32'h8000_7FFF, 32'hC000_8000, 32'h3FFF_8000};
    vecs[6]  = '{32'hFFFF_8000, 32'h0000_8000, 32'h7FFF_8000};
    vecs[7]  = '{32'h0002_FFFF, 32'hFFFF_FFFE, 32'h0001_FFFE};
    vecs[8]  = '{32'h0010_0010, 32'h0000_0100, 32'h0000_0100};
    vecs[9]  = '{32'h1234_0005, 32'h0000_5B04, 32'h0000_5B04};
    vecs[10] = '{32'h7FFF_7FFF, 32'h3FFF_0001, 32'h3FFF_0001};
    vecs[11] = '{32'hFFFE_0003, 32'hFFFF_FFFA, 32'h0002_FFFA};

    rst_n        = 1'b0;
    bif.operator = '0;
    repeat (2) @(negedge clk);
    check("rst_prod", 64'(bif.product), 64'd0);
    check("rst_finish", 64'(bif.finish), 64'd0);
    check("rst_busy", 64'(bif.busy), 64'd0);

    rst_n = 1'b1;
    run_op(32'h0, 32'h0, "por");

    // Constant operand: result must be held, never recomputed.
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bif.finish || bif.busy) drops++;
    end
    check("hold_const", 64'(drops), 64'd0);
    check("hold_prod", 64'(bif.product), 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, SGN ? vecs[i].exp_s : vecs[i].exp_u, $sformatf("vec%0d", i));
    end

    // Operand change mid-CALC: old operand finishes, then an automatic restart.
    bif.operator = 32'h0005_0003;
    repeat (4) @(negedge clk);
    bif.operator = 32'hFFFF_FFFF;
    lat = 0;
    while (!bif.finish && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("midchg_old_prod", 64'(bif.product), 64'h0000_000F);
    len = 0;
    while (bif.finish && len < 32) begin
      @(negedge clk);
      len++;
    end
    check("midchg_pulse", 64'(len), 64'(DH));
    lat = 0;
    while (!bif.finish && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("midchg_new_prod", 64'(bif.product), SGN ? 64'h0000_0001 : 64'hFFFE_0001);
    repeat (DH) @(negedge clk);

    // Reset in the middle of CALC discards the partial result.
    bif.operator = 32'h7FFF_8000;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_prod", 64'(bif.product), 64'd0);
    check("midrst_finish", 64'(bif.finish), 64'd0);
    check("midrst_busy", 64'(bif.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h7FFF_8000, SGN ? 32'hC000_8000 : 32'h3FFF_8000, "postrst");

    // Closed loop: next operand presented on every finish rising edge.
    min_len  = 1000;
    unstable = 0;
    n_to     = 0;
    last_res = '0;
    cur      = 32'h1234_FFF0;
    bif.operator = cur;
    for (int k = 0; k < 1000; k++) begin
      len = 0;
      while (bif.finish && len < 32) begin
        if (k > 0 && bif.product !== last_res) unstable++;
        @(negedge clk);
        len++;
      end
      if (len >= 32) n_to++;
      if (k > 0 && len < min_len) min_len = len;
      lat = 0;
      while (!bif.finish && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      if (lat >= 64) n_to++;
      last_res = ref_mul(cur);
      check("loop_prod", 64'(bif.product), 64'(last_res));
      cur = cur + 32'd1;
      bif.operator = cur;
    end
    check("loop_min_pulse", 64'(min_len), 64'(DH));
    check("loop_stable", 64'(unstable), 64'd0);
    check("loop_timeouts", 64'(n_to), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
